// File: rtl/reaction_tester_mc.sv
// Multi-player reaction tester: random hold-off, shared active-low hint, per-channel
// millisecond timestamps with EARLY/LATE/OK classification and first-OK winner pick.
module reaction_tester_mc #(
    parameter int          CLK_FREQ        = 50_000_000,
    parameter int          CHANNELS        = 4,
    parameter int          MAX_RT_MS       = 511,
    parameter int          MIN_RT_MS       = 100,
    parameter int          DELAY_BASE_MS   = 1024,
    parameter int          DELAY_SPAN_LOG2 = 12,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    localparam int         RW              = $clog2(MAX_RT_MS + 1),
    localparam int         WW              = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CHANNELS-1:0]    confirm,
    output logic                   hint,
    output logic                   busy,
    output logic [CHANNELS*RW-1:0] result,
    output logic [CHANNELS*2-1:0]  status,
    output logic [WW-1:0]          winner,
    output logic                   winner_valid,
    output logic                   done
);
    localparam int TPM  = CLK_FREQ / 1000;
    localparam int PW   = (TPM > 1) ? $clog2(TPM) : 1;
    localparam int DMAX = DELAY_BASE_MS + (1 << DELAY_SPAN_LOG2) - 1;
    localparam int TMAX = (DMAX > MAX_RT_MS) ? DMAX : MAX_RT_MS;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [1:0] ST_NONE  = 2'b00;
    localparam logic [1:0] ST_EARLY = 2'b01;
    localparam logic [1:0] ST_LATE  = 2'b10;
    localparam logic [1:0] ST_OK    = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_TEST, S_DONE} state_t;

    state_t                       state_q, state_d;
    logic [15:0]                  lfsr_q, lfsr_d;
    logic [PW-1:0]                presc_q, presc_d;
    logic [TW-1:0]                timer_q, timer_d;
    logic [TW-1:0]                delay_q, delay_d;
    logic [CHANNELS-1:0][1:0]     st_q, st_d;
    logic [CHANNELS-1:0][RW-1:0]  res_q, res_d;
    logic [WW-1:0]                win_q, win_d;
    logic                         winv_q, winv_d;
    logic                         done_q, done_d;
    logic                         tick;
    logic [CHANNELS-1:0]          ok_hit;
    logic [WW-1:0]                win_pick;

    function automatic logic all_closed(input logic [CHANNELS-1:0][1:0] s);
        logic r;
        r = 1'b1;
        for (int i = 0; i < CHANNELS; i++)
            if (s[i] == ST_NONE) r = 1'b0;
        return r;
    endfunction

    assign tick = (presc_q == PW'(TPM - 1));

    always_comb begin
        state_d  = state_q;
        lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        presc_d  = presc_q;
        timer_d  = timer_q;
        delay_d  = delay_q;
        st_d     = st_q;
        res_d    = res_q;
        win_d    = win_q;
        winv_d   = winv_q;
        ok_hit   = '0;
        win_pick = '0;
        if (state_q == S_WAIT || state_q == S_TEST) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            timer_d = tick ? timer_q + TW'(1) : timer_q;
        end
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_WAIT;
                    delay_d = TW'(DELAY_BASE_MS) + TW'(lfsr_q[DELAY_SPAN_LOG2-1:0]);
                    st_d    = '0;
                    res_d   = '0;
                    win_d   = '0;
                    winv_d  = 1'b0;
                    presc_d = '0;
                    timer_d = '0;
                end
            end
            S_WAIT: begin
                for (int i = 0; i < CHANNELS; i++)
                    if (confirm[i] && st_q[i] == ST_NONE) st_d[i] = ST_EARLY;
                // Everyone jumped the gun: finish without ever showing the hint.
                if (all_closed(st_d)) begin
                    state_d = S_DONE;
                end else if (timer_q == delay_q) begin
                    state_d = S_TEST;
                    presc_d = '0;
                    timer_d = '0;
                end
            end
            S_TEST: begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (confirm[i] && st_q[i] == ST_NONE) begin
                        if (timer_q < TW'(MIN_RT_MS)) begin
                            st_d[i] = ST_EARLY;
                        end else begin
                            st_d[i]   = ST_OK;
                            res_d[i]  = timer_q[RW-1:0];
                            ok_hit[i] = 1'b1;
                        end
                    end
                end
                for (int i = CHANNELS - 1; i >= 0; i--)
                    if (ok_hit[i]) win_pick = WW'(i);
                if (!winv_q && (|ok_hit)) begin
                    win_d  = win_pick;
                    winv_d = 1'b1;
                end
                // Timeout closes only what this cycle's presses left open.
                if (tick && timer_q == TW'(MAX_RT_MS - 1)) begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (st_d[i] == ST_NONE) begin
                            st_d[i]  = ST_LATE;
                            res_d[i] = RW'(MAX_RT_MS);
                        end
                    end
                    state_d = S_DONE;
                end else if (all_closed(st_d)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        done_d = (state_d == S_DONE) && (state_q != S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_SEED;
            presc_q <= '0;
            timer_q <= '0;
            delay_q <= '0;
            st_q    <= '0;
            res_q   <= '0;
            win_q   <= '0;
            winv_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            presc_q <= presc_d;
            timer_q <= timer_d;
            delay_q <= delay_d;
            st_q    <= st_d;
            res_q   <= res_d;
            win_q   <= win_d;
            winv_q  <= winv_d;
            done_q  <= done_d;
        end
    end

    assign hint         = (state_q != S_TEST);
    assign busy         = (state_q == S_WAIT) || (state_q == S_TEST);
    assign result       = res_q;
    assign status       = st_q;
    assign winner       = win_q;
    assign winner_valid = winv_q;
    assign done         = done_q;
endmodule
